// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg
//   Shared definitions for the 7-segment display blocks.
//   - seg7_t              : segment pattern {g,f,e,d,c,b,a}, active-low
//   - SEG_0..SEG_9        : digit glyphs
//   - SEG_DASH, SEG_BLANK : non-BCD glyph and all-segments-off
//   - cnt_width()         : counter width for a modulus, never below 1 bit
package bcd_display_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_0     = 7'h40;
    localparam seg7_t SEG_1     = 7'h79;
    localparam seg7_t SEG_2     = 7'h24;
    localparam seg7_t SEG_3     = 7'h30;
    localparam seg7_t SEG_4     = 7'h19;
    localparam seg7_t SEG_5     = 7'h12;
    localparam seg7_t SEG_6     = 7'h02;
    localparam seg7_t SEG_7     = 7'h78;
    localparam seg7_t SEG_8     = 7'h00;
    localparam seg7_t SEG_9     = 7'h10;
    localparam seg7_t SEG_DASH  = 7'h3F;
    localparam seg7_t SEG_BLANK = 7'h7F;

    // Width of a counter that runs 0..n-1 (prescaler, scan index).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7
//   Combinational BCD to active-low 7-segment decoder. Codes 10..15 show a dash.
//   Ports:
//     bcd  in  4  BCD digit
//     seg  out 7  {g,f,e,d,c,b,a}, active-low
import bcd_display_pkg::*;

module bcd_to_seg7 (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// bcd_display_scan
//   Time-multiplexed 7-segment driver for a row of BCD digits. Captures the
//   digits on load, then scans them one slot at a time with one dead cycle per
//   slot, optional leading-zero blanking and per-digit decimal points.
//   Ports:
//     clk         in  1           clock
//     reset       in  1           synchronous, active-high
//     digits_in   in  4*DIGITS    packed BCD, digit 0 least significant
//     dp_in       in  DIGITS      decimal-point request per digit
//     load        in  1           capture digits_in/dp_in
//     blank_en    in  1           leading-zero blanking enable (live)
//     seg_n       out 7           {g,f,e,d,c,b,a}, active-low
//     dp_n        out 1           decimal point, active-low
//     an_n        out DIGITS      anode selects, active-low
//     frame_done  out 1           pulse on the first cycle of a wrapped frame
import bcd_display_pkg::*;

module bcd_display_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_en,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_done
);

    localparam int PW = cnt_width(PRESCALE);
    localparam int IW = cnt_width(DIGITS);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] snap_digits;
    logic [DIGITS-1:0]   snap_dp;
    logic [PW-1:0]       pcnt;
    logic [IW-1:0]       idx;
    logic                wrap_q;

    logic [3:0]          cur_bcd;
    logic [6:0]          dec_seg;
    logic                upper_zero;
    logic                digit_blank;
    logic [6:0]          seg_next;
    logic                dp_next;
    logic [DIGITS-1:0]   an_next;
    logic                slot_end;

    assign cur_bcd  = snap_digits[4*int'(idx) +: 4];
    assign slot_end = (pcnt == PCNT_LAST);

    bcd_to_seg7 u_dec (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    // A digit is a leading zero when it and every more significant digit are 0.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx) && snap_digits[4*i +: 4] != 4'd0)
                upper_zero = 1'b0;
        end
    end

    assign digit_blank = blank_en && (idx != '0) && upper_zero;
    assign seg_next    = digit_blank ? SEG_BLANK : dec_seg;
    assign dp_next     = digit_blank ? 1'b1 : ~snap_dp[idx];
    // pcnt == 0 is the dead cycle between slots: all anodes off.
    assign an_next     = (pcnt == '0) ? '1 : ~(DIGITS'(1) << idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_digits <= '0;
            snap_dp     <= '0;
            pcnt        <= '0;
            idx         <= '0;
            wrap_q      <= 1'b0;
            seg_n       <= SEG_BLANK;
            dp_n        <= 1'b1;
            an_n        <= '1;
            frame_done  <= 1'b0;
        end else begin
            if (load) begin
                snap_digits <= digits_in;
                snap_dp     <= dp_in;
            end
            if (slot_end) begin
                pcnt <= '0;
                idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            // wrap_q marks the idx 0 / pcnt 0 state entered by a wrap, so the
            // registered pulse lines up with that state's outputs.
            wrap_q     <= slot_end && (idx == IDX_LAST);
            seg_n      <= seg_next;
            dp_n       <= dp_next;
            an_n       <= an_next;
            frame_done <= wrap_q;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
module tb_bcd_display_scan;

    logic        clk;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_en;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    bcd_display_scan #(.DIGITS(4), .PRESCALE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank_en   (blank_en),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output for the sample after posedge number e.
    // m selects fields to check: [3]=seg [2]=dp [1]=an [0]=frame_done
    typedef struct {
        int         e;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fd;
        logic [3:0] m;
        string      nm;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    logic ok;

    logic [6:0] tseg [4];
    logic       tdp  [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int e, input logic [6:0] s, input logic d,
                        input logic [3:0] a, input logic f, input logic [3:0] m,
                        input string nm);
        exp_t x;
        x.e = e; x.seg = s; x.dp = d; x.an = a; x.fd = f; x.m = m; x.nm = nm;
        sb.push_back(x);
    endtask

    // Slot k after the first reset release: dead cycle at edge 4+4k, active
    // edges after it, digit index k mod 4, frame_done on every 4th slot but 0.
    task automatic push_slots(input int k0, input int k1);
        int d, ix;
        for (int k = k0; k <= k1; k++) begin
            d  = 4 + 4*k;
            ix = k % 4;
            push(d, 7'h7F, 1'b1, 4'hF, (ix == 0 && k > 0), 4'b0011, "dead");
            for (int j = 1; j <= 3; j++)
                push(d + j, tseg[ix], tdp[ix], ~(4'b0001 << ix), 1'b0, 4'b1111, "slot");
        end
    endtask

    task automatic set_tab(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] dps);
        tseg[0] = s0; tseg[1] = s1; tseg[2] = s2; tseg[3] = s3;
        for (int i = 0; i < 4; i++) tdp[i] = dps[i];
    endtask

    // Return once inputs set now will be sampled at posedge number e.
    task automatic at_edge(input int e);
        while (cyc != e - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].e <= cyc) begin
            cur = sb.pop_front();
            total++;
            if (cur.e < cyc) begin
                bad++;
                $display("FAIL %s edge %0d: sampled at edge %0d, required %0d", cur.nm, cur.e, cyc, cur.e);
            end else begin
                ok = 1'b1;
                if (cur.m[3] && seg_n      !== cur.seg) ok = 1'b0;
                if (cur.m[2] && dp_n       !== cur.dp)  ok = 1'b0;
                if (cur.m[1] && an_n       !== cur.an)  ok = 1'b0;
                if (cur.m[0] && frame_done !== cur.fd)  ok = 1'b0;
                if (!ok) begin
                    bad++;
                    $display("FAIL %s edge %0d: got seg=%h dp=%b an=%h fd=%b, required seg=%h dp=%b an=%h fd=%b (mask %b)",
                             cur.nm, cur.e, seg_n, dp_n, an_n, frame_done,
                             cur.seg, cur.dp, cur.an, cur.fd, cur.m);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending, required 0", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        blank_en  = 1'b0;

        // Reset held for edges 1..3, then digit-0 dead cycle and slot.
        for (int e = 1; e <= 3; e++)
            push(e, 7'h7F, 1'b1, 4'hF, 1'b0, 4'b1111, "reset");
        set_tab(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
        push_slots(0, 0);
        at_edge(4);
        reset = 1'b0;

        // Scan order over two frames.
        set_tab(7'h79, 7'h24, 7'h30, 7'h19, 4'b1111);
        push_slots(1, 8);
        at_edge(8);
        load = 1'b1; digits_in = 16'h4321; dp_in = 4'b0000;
        at_edge(9);
        load = 1'b0;

        // Leading-zero blanking.
        set_tab(7'h40, 7'h10, 7'h7F, 7'h7F, 4'b1111);
        push_slots(9, 12);
        at_edge(40);
        load = 1'b1; digits_in = 16'h0090; blank_en = 1'b1;
        at_edge(41);
        load = 1'b0;

        set_tab(7'h40, 7'h10, 7'h40, 7'h40, 4'b1111);
        push_slots(13, 16);
        at_edge(56);
        blank_en = 1'b0;

        // Invalid code and decimal point.
        set_tab(7'h12, 7'h3F, 7'h40, 7'h40, 4'b1101);
        push_slots(17, 20);
        at_edge(72);
        load = 1'b1; digits_in = 16'h00A5; dp_in = 4'b0010;
        at_edge(73);
        load = 1'b0;

        // Load on the wrap edge (pcnt 3 -> 0 at edge 87).
        set_tab(7'h00, 7'h00, 7'h00, 7'h00, 4'b1111);
        push_slots(21, 21);
        at_edge(87);
        load = 1'b1; digits_in = 16'h8888; dp_in = 4'b0000;
        at_edge(88);
        load = 1'b0;

        // Reset during the idx 2 slot (dead at 92, active from 93).
        push(92, 7'h7F, 1'b1, 4'hF, 1'b0, 4'b0011, "pre_rst_dead");
        push(93, 7'h00, 1'b1, 4'hB, 1'b0, 4'b1111, "pre_rst_act");
        push(94, 7'h7F, 1'b1, 4'hF, 1'b0, 4'b1111, "mid_reset");
        push(95, 7'h7F, 1'b1, 4'hF, 1'b0, 4'b0011, "restart_dead");
        for (int e = 96; e <= 98; e++)
            push(e, 7'h40, 1'b1, 4'hE, 1'b0, 4'b1111, "restart_d0");
        push(99, 7'h7F, 1'b1, 4'hF, 1'b0, 4'b0011, "restart_dead1");
        for (int e = 100; e <= 102; e++)
            push(e, 7'h40, 1'b1, 4'hD, 1'b0, 4'b1111, "restart_d1");
        at_edge(94);
        reset = 1'b1;
        at_edge(95);
        reset = 1'b0;

        for (int i = 0; i < 200 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Time-multiplexed 7-segment display driver for a row of decade (BCD 0–9) counter digits. It sits directly downstream of the sequential BCD counters. It captures their packed 4-bit digit outputs on a load strobe, then scans one digit at a time onto a shared active-low segment bus and drives active-low anode selects. It supports leading-zero blanking, per-digit decimal points, and dead time between digit slots.

## Interface
- DIGITS, 4: number of digits scanned; legal 1..8.
- PRESCALE, 1000: clk cycles per digit slot; legal ≥ 2.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- digits_in  in  4*DIGITS  packed BCD; digit i is bits [4i+3:4i], and digit 0 is least significant.
- dp_in  in  DIGITS  decimal-point request per digit.
- load  in  1  captures digits_in/dp_in into the snapshot register.
- blank_en  in  1  enables leading-zero blanking; sampled live, not captured.
- seg_n  out  7  {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- an_n  out  DIGITS  anode selects, active-low, one-hot-low or all-high.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- **State:**
  - snapshot (digits, dp), reset to 0.
  - prescaler pcnt, 0..PRESCALE-1, reset to 0.
  - scan index idx, 0..DIGITS-1, reset to 0.
- **load:** snapshot ← digits_in/dp_in on the same edge. If load coincides with a slot change, both updates occur. There is no handshake; load is a level-sampled strobe.
- **Prescaler:**
  - pcnt increments every cycle.
  - At PRESCALE-1, pcnt wraps to 0 and idx advances.
  - When idx is DIGITS-1, it wraps to 0.
- **Dead time:** while pcnt == 0, the decoded an_n is all ones. This provides one blanked cycle per slot.
- **Digit decode**, for d = snapshot digit idx:
  - 0 = 0x40, 1 = 0x79, 2 = 0x24, 3 = 0x30, 4 = 0x19, 5 = 0x12, 6 = 0x02, 7 = 0x78, 8 = 0x00, 9 = 0x10.
  - Any value 10–15 shows 0x3F (only segment g lit, shown as "-").
- **Leading-zero blanking:**
  - Digit idx is blank when blank_en = 1, idx ≠ 0, and all snapshot digits at positions ≥ idx are 0.
  - A blank digit drives seg_n = 0x7F and dp_n = 1. Its anode is still driven.
  - Digit 0 is never blanked.
- **dp_n** = ~snapshot.dp[idx] unless the digit is blanked.
- **frame_done** is asserted for the cycle whose outputs correspond to the idx 0 / pcnt 0 state after a wrap. It is not asserted for the first slot after reset.
- **Reset mid-scan:** all state returns to reset values on that edge. Any partially shown slot is abandoned.

## Timing
- All outputs are registered. Outputs in cycle n+1 reflect the state (snapshot, pcnt, idx) and blank_en of cycle n, so latency is 1 cycle.
- **Reset values:** seg_n = 0x7F, dp_n = 1, an_n = all ones, frame_done = 0.
- **First cycle after reset release:** outputs decode pcnt = 0, so an_n is all ones (dead time).
- **Next cycle:** an_n[0] = 0, showing snapshot digit 0.
- Slot length is exactly PRESCALE cycles, of which PRESCALE-1 are active. Frame length is DIGITS·PRESCALE cycles.
- A load at edge k is visible on seg_n at edge k+1, in whatever slot is current.
- **DIGITS = 1:** idx stays 0, and frame_done pulses once every PRESCALE cycles after the first.

## Structure
- **Package bcd_display_pkg:**
  - Segment constants: SEG_0..SEG_9, SEG_DASH = 7'h3F, SEG_BLANK = 7'h7F.
  - Type seg7_t (7-bit).
  - Localparam helper for prescaler width $clog2(PRESCALE).
- **Sub-module bcd_to_seg7:** combinational 4-bit → seg7_t decoder, reused by other display blocks.
- **Top:** holds the snapshot register, prescaler, scan counter, blanking logic and output registers.

## Test plan
All scenarios use PRESCALE = 4 and DIGITS = 4.
- **Reset/start:** hold reset 3 cycles, then release.
  - Required: reset outputs 0x7F / 1 / 4'hF / 0.
  - Then one cycle with an_n = 4'hF, followed by 3 cycles with an_n = 4'hE and seg_n = 0x40.
- **Scan order:** load digits_in = 0x4321, blank_en = 0.
  - Required: an_n steps E, D, B, 7 with seg_n 0x79, 0x24, 0x30, 0x19.
  - Each slot is 1 dead cycle followed by 3 active cycles.
  - frame_done pulses once per 16 cycles, at the start of the idx-0 slot.
- **Blanking:** load 0x0090, blank_en = 1.
  - Required: digit 0 shows 0x40, digit 1 shows 0x10, digits 2 and 3 show seg_n 0x7F with their anodes driven.
  - Clear blank_en: digits 2 and 3 show 0x40.
- **Invalid and DP:** load 0x00A5 with dp_in = 4'b0010.
  - Required: digit 0 shows 0x12 with dp_n = 1; digit 1 shows 0x3F with dp_n = 0.
- **Load/slot collision:** assert load (0x8888) on the edge where pcnt wraps.
  - Required: the new slot shows 0x00 from its first active cycle.
- **Reset mid-scan:** assert reset during the idx = 2 slot.
  - Required: reset values appear next cycle, and the snapshot is 0.
  - After release, the scan restarts at the digit-0 dead cycle.
